// File: rtl/tb_obi_pkg.sv
// OBI bus constants and request/response bundles shared by the memory arbiter slice.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package tb_obi_pkg;

  localparam int OBI_ADDR_W = 32;
  localparam int OBI_DATA_W = 32;

  typedef struct packed {
    logic [OBI_ADDR_W-1:0]   addr;
    logic                    we;
    logic [OBI_DATA_W/8-1:0] be;
    logic [OBI_DATA_W-1:0]   wdata;
  } obi_req_t;

  typedef struct packed {
    logic                  rvalid;
    logic [OBI_DATA_W-1:0] rdata;
  } obi_rsp_t;

endpackage

// File: rtl/tb_obi_id_fifo.sv
// Synchronous FIFO of requester IDs for in-order OBI response routing.
// Latency: push visible at head the following cycle; head read combinationally.
// Backpressure: full/empty flags; caller must not push when full nor pop when empty.
module tb_obi_id_fifo #(
  parameter int W     = 1,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_vld,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_vld,
  output logic [W-1:0]  pop_dat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk_i) begin
    if (push_vld) mem[wr_ptr] <= push_dat;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_vld) wr_ptr <= wr_ptr + PW'(1);
      if (pop_vld)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_vld, pop_vld})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign pop_dat = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/tb_obi_mem_arbiter.sv
// Round-robin arbiter sharing one OBI memory slave port among NUM_MASTERS requesters.
// Latency: zero added request latency; responses routed to the owning master in the same cycle.
// Backpressure: slave gnt passed through to the selected master; requests held off while the ID FIFO is full.
module tb_obi_mem_arbiter
  import tb_obi_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ADDR_WIDTH      = OBI_ADDR_W,
  parameter int DATA_WIDTH      = OBI_DATA_W,
  localparam int BE_WIDTH       = DATA_WIDTH / 8,
  localparam int OCNT_W         = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic [NUM_MASTERS-1:0]            m_req_i,
  output logic [NUM_MASTERS-1:0]            m_gnt_o,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_be_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]            m_rvalid_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_o,
  output logic                              s_req_o,
  input  logic                              s_gnt_i,
  output logic [ADDR_WIDTH-1:0]             s_addr_o,
  output logic                              s_we_o,
  output logic [BE_WIDTH-1:0]               s_be_o,
  output logic [DATA_WIDTH-1:0]             s_wdata_o,
  input  logic                              s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]             s_rdata_i,
  output logic [OCNT_W-1:0]                 outstanding_o,
  output logic                              err_o
);

  localparam int IDX_W = $clog2(NUM_MASTERS);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] lock_idx;
  logic             locked;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_found;
  logic [IDX_W-1:0] sel;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] head;
  logic             hs;
  logic             pop;

  // First requester at or after rr_ptr, wrapping modulo NUM_MASTERS.
  always_comb begin
    int j;
    j         = 0;
    arb_found = 1'b0;
    arb_idx   = rr_ptr;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_MASTERS) j = j - NUM_MASTERS;
      if (!arb_found && m_req_i[j]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'(j);
      end
    end
  end

  // A stalled request stays on the bus until granted, even if its master drops req.
  assign sel     = locked ? lock_idx : arb_idx;
  assign s_req_o = (locked || arb_found) && !fifo_full;
  assign hs      = s_req_o && s_gnt_i;

  assign s_addr_o  = m_addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign s_we_o    = m_we_i[sel];
  assign s_be_o    = m_be_i[int'(sel)*BE_WIDTH +: BE_WIDTH];
  assign s_wdata_o = m_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

  assign m_gnt_o = hs ? (NUM_MASTERS'(1) << sel) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr   <= '0;
      lock_idx <= '0;
      locked   <= 1'b0;
    end else begin
      if (s_req_o && !s_gnt_i) begin
        locked   <= 1'b1;
        lock_idx <= sel;
      end else if (hs) begin
        locked <= 1'b0;
      end
      if (hs) rr_ptr <= (sel == IDX_W'(NUM_MASTERS - 1)) ? '0 : sel + IDX_W'(1);
    end
  end

  assign pop = s_rvalid_i && !fifo_empty;

  tb_obi_id_fifo #(
    .W     (IDX_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_vld (hs),
    .push_dat (sel),
    .pop_vld  (pop),
    .pop_dat  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (outstanding_o)
  );

  assign m_rvalid_o = pop ? (NUM_MASTERS'(1) << head) : '0;
  assign m_rdata_o  = {NUM_MASTERS{s_rdata_i}};

  // A response with nothing outstanding means the slave and arbiter disagree; keep it visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       err_o <= 1'b0;
    else if (s_rvalid_i && fifo_empty) err_o <= 1'b1;
  end

endmodule
